// File: rtl/indirect_bank_tracker_pkg.sv
// Shared constants for the 6509 indirect-bank tracker.
// This package holds the state encoding and the opcode match for LDA/STA (zp),Y.
package indirect_bank_tracker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_OPR  = 3'd1,
    ST_PLO  = 3'd2,
    ST_PHI  = 3'd3,
    ST_FIX  = 3'd4,
    ST_DAT  = 3'd5
  } state_t;

  // Bit 5 is the only difference between $91 and $B1, so it is masked out.
  localparam logic [7:0] OPC_MASK = 8'hDF;
  localparam logic [7:0] OPC_VAL  = 8'h91;

endpackage

// File: rtl/indirect_bank_tracker_if.sv
// CPU-side bus signals observed by the tracker, and the tracker outputs.
// The master modport is the CPU/socket side; the slave modport is the tracker.
interface indirect_bank_tracker_if;

  logic       sync;
  logic       r_w;
  logic       _rdy;
  logic [7:0] data_6502;
  logic       ext_mode;
  logic       sel_bank;
  logic       busy;
  logic       is_store;
  logic [2:0] cyc;

  modport master (
    output sync, r_w, _rdy, data_6502, ext_mode,
    input  sel_bank, busy, is_store, cyc
  );

  modport slave (
    input  sync, r_w, _rdy, data_6502, ext_mode,
    output sel_bank, busy, is_store, cyc
  );

endinterface

// File: rtl/indirect_bank_tracker.sv
// Bus-cycle tracker for LDA/STA (zp),Y that drives sel_bank for the bank mux.
// state | meaning: IDLE none, OPR zp fetch, PLO ptr lo, PHI ptr hi, FIX 1st indirect, DAT 2nd indirect/next opcode
module indirect_bank_tracker
  import indirect_bank_tracker_pkg::*;
(
  input  logic                    phi2_6509,
  input  logic                    _reset,
  indirect_bank_tracker_if.slave  bus
);

  state_t r_state;
  state_t w_next;
  logic   r_is_store;
  logic   w_qual;
  logic   w_complete;
  logic   w_load_op;

  assign w_qual     = bus.sync && ((bus.data_6502 & OPC_MASK) == OPC_VAL);
  // NMOS 6502 ignores RDY on write cycles, so writes always complete.
  assign w_complete = bus._rdy || !bus.r_w;
  assign w_load_op  = w_complete && !bus.ext_mode && w_qual;

  always_comb begin
    w_next = r_state;
    if (bus.ext_mode) begin
      w_next = ST_IDLE;
    end else if (w_complete) begin
      case (r_state)
        ST_IDLE: w_next = w_qual ? ST_OPR : ST_IDLE;
        ST_OPR:  w_next = bus.sync ? (w_qual ? ST_OPR : ST_IDLE) : ST_PLO;
        ST_PLO:  w_next = bus.sync ? (w_qual ? ST_OPR : ST_IDLE) : ST_PHI;
        ST_PHI:  w_next = bus.sync ? (w_qual ? ST_OPR : ST_IDLE) : ST_FIX;
        ST_FIX:  w_next = bus.sync ? (w_qual ? ST_OPR : ST_IDLE) : ST_DAT;
        ST_DAT:  w_next = w_qual ? ST_OPR : ST_IDLE;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(negedge phi2_6509 or negedge _reset) begin
    if (!_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Every qualifying completed opcode fetch enters OPR, so latch the store flag there.
  always_ff @(negedge phi2_6509 or negedge _reset) begin
    if (!_reset) begin
      r_is_store <= 1'b0;
    end else if (w_load_op) begin
      r_is_store <= !bus.data_6502[5];
    end
  end

  assign bus.sel_bank = !bus.ext_mode &&
                        ((r_state == ST_FIX) || ((r_state == ST_DAT) && !bus.sync));
  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.is_store = r_is_store;
  assign bus.cyc      = r_state;

endmodule

// File: tb/tb_indirect_bank_tracker.sv
// Directed bench for indirect_bank_tracker: one bus cycle per step, with hand-computed expectations.
module tb_indirect_bank_tracker;

  logic phi2_6509;
  logic _reset;
  int   n_pass;
  int   n_total;

  indirect_bank_tracker_if bus ();

  indirect_bank_tracker dut (
    .phi2_6509 (phi2_6509),
    ._reset    (_reset),
    .bus       (bus)
  );

  initial phi2_6509 = 1'b0;
  always #10 phi2_6509 = ~phi2_6509;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input logic [2:0] e_cyc, input logic e_sel,
                         input logic e_busy, input logic e_st);
    chk({tag, ".cyc"},      {5'd0, bus.cyc},      {5'd0, e_cyc});
    chk({tag, ".sel_bank"}, {7'd0, bus.sel_bank}, {7'd0, e_sel});
    chk({tag, ".busy"},     {7'd0, bus.busy},     {7'd0, e_busy});
    chk({tag, ".is_store"}, {7'd0, bus.is_store}, {7'd0, e_st});
  endtask

  // Drive one bus cycle just after the falling edge, check mid-cycle, then advance.
  task automatic step(input logic s, input logic rw, input logic rdy, input logic [7:0] d,
                      input logic ext, input logic [2:0] e_cyc, input logic e_sel,
                      input logic e_busy, input logic e_st, input string tag);
    bus.sync      = s;
    bus.r_w       = rw;
    bus._rdy      = rdy;
    bus.data_6502 = d;
    bus.ext_mode  = ext;
    @(posedge phi2_6509);
    chk_all(tag, e_cyc, e_sel, e_busy, e_st);
    @(negedge phi2_6509);
    #1;
  endtask

  initial begin
    n_pass        = 0;
    n_total       = 0;
    _reset        = 1'b0;
    bus.sync      = 1'b0;
    bus.r_w       = 1'b1;
    bus._rdy      = 1'b1;
    bus.data_6502 = 8'h00;
    bus.ext_mode  = 1'b0;
    #3;
    chk_all("reset", 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge phi2_6509);
    #1;
    _reset = 1'b1;

    // LDA (zp),Y, no page cross, followed by NOP
    step(1, 1, 1, 8'hB1, 0, 3'd0, 0, 0, 0, "lda_c1");
    step(0, 1, 1, 8'h20, 0, 3'd1, 0, 1, 0, "lda_c2");
    step(0, 1, 1, 8'h00, 0, 3'd2, 0, 1, 0, "lda_c3");
    step(0, 1, 1, 8'h30, 0, 3'd3, 0, 1, 0, "lda_c4");
    step(0, 1, 1, 8'h55, 0, 3'd4, 1, 1, 0, "lda_c5");
    step(1, 1, 1, 8'hEA, 0, 3'd5, 0, 1, 0, "lda_c6");
    step(0, 1, 1, 8'h00, 0, 3'd0, 0, 0, 0, "lda_idle");

    // STA (zp),Y with _rdy low during the DAT write: no stall
    step(1, 1, 1, 8'h91, 0, 3'd0, 0, 0, 0, "sta_c1");
    step(0, 1, 1, 8'h20, 0, 3'd1, 0, 1, 1, "sta_c2");
    step(0, 1, 1, 8'h00, 0, 3'd2, 0, 1, 1, "sta_c3");
    step(0, 1, 1, 8'h30, 0, 3'd3, 0, 1, 1, "sta_c4");
    step(0, 1, 1, 8'h00, 0, 3'd4, 1, 1, 1, "sta_c5");
    step(0, 0, 0, 8'hA5, 0, 3'd5, 1, 1, 1, "sta_c6");
    step(0, 1, 1, 8'h00, 0, 3'd0, 0, 0, 1, "sta_idle");

    // LDA with a 3-cycle read stall in PHI, then STA back-to-back at the DAT sync
    step(1, 1, 1, 8'hB1, 0, 3'd0, 0, 0, 1, "stall_c1");
    step(0, 1, 1, 8'h20, 0, 3'd1, 0, 1, 0, "stall_c2");
    step(0, 1, 1, 8'h00, 0, 3'd2, 0, 1, 0, "stall_c3");
    step(0, 1, 0, 8'h30, 0, 3'd3, 0, 1, 0, "stall_w1");
    step(0, 1, 0, 8'h30, 0, 3'd3, 0, 1, 0, "stall_w2");
    step(0, 1, 0, 8'h30, 0, 3'd3, 0, 1, 0, "stall_w3");
    step(0, 1, 1, 8'h30, 0, 3'd3, 0, 1, 0, "stall_c4");
    step(0, 1, 1, 8'h55, 0, 3'd4, 1, 1, 0, "stall_c5");
    step(1, 1, 1, 8'h91, 0, 3'd5, 0, 1, 0, "b2b_dat");
    step(0, 1, 1, 8'h40, 0, 3'd1, 0, 1, 1, "b2b_opr");
    step(0, 1, 1, 8'h00, 0, 3'd2, 0, 1, 1, "b2b_plo");
    step(0, 1, 1, 8'h30, 0, 3'd3, 0, 1, 1, "b2b_phi");

    // asynchronous reset in the middle of FIX
    bus.sync = 1'b0;
    bus.r_w  = 1'b1;
    bus._rdy = 1'b1;
    #2;
    chk_all("rst_pre", 3'd4, 1'b1, 1'b1, 1'b1);
    _reset = 1'b0;
    #1;
    chk_all("rst_fix", 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge phi2_6509);
    #1;
    _reset = 1'b1;

    // clean start after reset, then ext_mode in PLO
    step(1, 1, 1, 8'hB1, 0, 3'd0, 0, 0, 0, "ext_c1");
    step(0, 1, 1, 8'h20, 0, 3'd1, 0, 1, 0, "ext_c2");
    step(0, 1, 1, 8'h00, 1, 3'd2, 0, 1, 0, "ext_plo");
    step(0, 1, 1, 8'h00, 0, 3'd0, 0, 0, 0, "ext_idle");

    // ext_mode gates sel_bank immediately in FIX
    step(1, 1, 1, 8'h91, 0, 3'd0, 0, 0, 0, "extf_c1");
    step(0, 1, 1, 8'h20, 0, 3'd1, 0, 1, 1, "extf_c2");
    step(0, 1, 1, 8'h00, 0, 3'd2, 0, 1, 1, "extf_c3");
    step(0, 1, 1, 8'h30, 0, 3'd3, 0, 1, 1, "extf_c4");
    step(0, 1, 1, 8'h00, 1, 3'd4, 0, 1, 1, "extf_fix");
    step(0, 1, 1, 8'h00, 0, 3'd0, 0, 0, 1, "extf_idle");

    // illegal sync mid-instruction: non-qualifying and qualifying re-decode
    step(1, 1, 1, 8'hB1, 0, 3'd0, 0, 0, 1, "ill_c1");
    step(0, 1, 1, 8'h20, 0, 3'd1, 0, 1, 0, "ill_c2");
    step(1, 1, 1, 8'hEA, 0, 3'd2, 0, 1, 0, "ill_plo_nop");
    step(0, 1, 1, 8'h00, 0, 3'd0, 0, 0, 0, "ill_idle");
    step(1, 1, 1, 8'hB1, 0, 3'd0, 0, 0, 0, "ill2_c1");
    step(0, 1, 1, 8'h20, 0, 3'd1, 0, 1, 0, "ill2_c2");
    step(1, 1, 1, 8'h91, 0, 3'd2, 0, 1, 0, "ill2_plo_sta");
    step(0, 1, 1, 8'h20, 0, 3'd1, 0, 1, 1, "ill2_opr");
    step(0, 1, 1, 8'h00, 0, 3'd2, 0, 1, 1, "ill2_plo");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
